// File: rtl/simd_processing_unit_if.sv
// Instruction-fetch and main-memory bus bundle for simd_processing_unit.
//   master: driven by the processing unit (requests, addresses, store data)
//   slave : driven by the instruction store / memory arbiter (data, valid, ack)
interface simd_processing_unit_if #(
    parameter int unsigned CORES = 32,
    parameter int unsigned BITS  = 16,
    parameter int unsigned PC_W  = 16
);
    logic                    imem_req;
    logic [PC_W-1:0]         imem_addr;
    logic [31:0]             imem_data;
    logic                    imem_valid;
    logic                    mem_req;
    logic                    mem_we;
    logic [PC_W-1:0]         mem_addr;
    logic [CORES*BITS-1:0]   mem_wdata;
    logic [CORES*BITS-1:0]   mem_rdata;
    logic                    mem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_data, imem_valid,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_data, imem_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/simd_processing_unit.sv
// SIMD processing unit: fetches 32-bit instructions over a req/valid handshake and
// executes them on CORES bf16 lanes sharing one register file; loads/stores use a
// req/ack handshake. Adds jump, counted loop, halt and a sticky illegal-opcode flag.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start          begin execution at pc=0 from IDLE or HALTED
//   busy           high in every state except IDLE and HALTED
//   halted         high in HALTED
//   illegal        sticky unknown-opcode flag (cleared only by reset)
//   bus            imem_* fetch port and mem_* main-memory port (master side)
// alu_ctrl per lane: 0 add, 1 subtract (src1 - src2), others move src1.
// Lanes are bf16, so BITS must be 16. Arithmetic flushes denormals to zero,
// truncates (round toward zero) and saturates overflow to infinity.
module simd_processing_unit #(
    parameter int unsigned CORES   = 32,
    parameter int unsigned BITS    = 16,
    parameter int unsigned REG_AW  = 8,
    parameter int unsigned PC_W    = 16,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic halted,
    output logic illegal,
    simd_processing_unit_if.master bus
);
    localparam int unsigned W     = CORES * BITS;
    localparam int unsigned NREGS = 1 << REG_AW;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned LAT_W = $clog2(ALU_LAT + 1);

    localparam logic [3:0] OP_ALU    = 4'd0;
    localparam logic [3:0] OP_STORE  = 4'd1;
    localparam logic [3:0] OP_LOAD   = 4'd2;
    localparam logic [3:0] OP_JUMP   = 4'd3;
    localparam logic [3:0] OP_SETCNT = 4'd4;
    localparam logic [3:0] OP_LOOP   = 4'd5;
    localparam logic [3:0] OP_NOP    = 4'd6;
    localparam logic [3:0] OP_HALT   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED
    } state_t;

    state_t            state, state_nx;
    logic [PC_W-1:0]   pc, pc_nx;
    logic [CNT_W-1:0]  loop_cnt, loop_nx;
    logic [31:0]       ir, ir_nx;
    logic              illegal_nx;
    logic [LAT_W-1:0]  cnt, cnt_nx;
    logic [W-1:0]      op_a, op_a_nx, op_b, op_b_nx;
    logic              mem_we_q, mem_we_nx;
    logic [PC_W-1:0]   mem_addr_q, mem_addr_nx;
    logic [W-1:0]      mem_wdata_q, mem_wdata_nx;
    logic              imem_req_q, mem_req_q;

    logic [W-1:0]      regs [NREGS];
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [W-1:0]      rf_wd;
    logic [W-1:0]      alu_out;

    // Instruction fields
    logic [3:0]        op, alu_ctrl;
    logic [REG_AW-1:0] dst_a, src1_a, src2_a;
    logic [PC_W-1:0]   imm;
    assign op       = ir[31:28];
    assign alu_ctrl = ir[27:24];
    assign dst_a    = REG_AW'(ir[23:16]);
    assign src1_a   = REG_AW'(ir[15:8]);
    assign src2_a   = REG_AW'(ir[7:0]);
    assign imm      = PC_W'(ir[15:0]);

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // bf16 add/subtract: align the smaller magnitude, add or subtract, renormalise
    function automatic logic [15:0] bf16_addsub(input logic [15:0] a, input logic [15:0] b_in,
                                                input logic sub);
        logic [15:0] b, x, y, r;
        logic [7:0]  d;
        logic [11:0] mx, my, s;
        int          e;
        b  = {b_in[15] ^ sub, b_in[14:0]};
        r  = 16'd0;
        x  = a;
        y  = b;
        d  = 8'd0;
        mx = 12'd0;
        my = 12'd0;
        s  = 12'd0;
        e  = 0;
        if (a[14:7] == 8'd0) begin
            r = (b[14:7] == 8'd0) ? 16'd0 : b;
        end else if (b[14:7] == 8'd0) begin
            r = a;
        end else begin
            if (a[14:0] < b[14:0]) begin
                x = b;
                y = a;
            end
            d  = x[14:7] - y[14:7];
            mx = {1'b0, 1'b1, x[6:0], 3'b000};
            my = (d > 8'd10) ? 12'd0 : ({1'b0, 1'b1, y[6:0], 3'b000} >> d);
            e  = int'(x[14:7]);
            if (x[15] == y[15]) begin
                s = mx + my;
                if (s[11]) begin
                    s = s >> 1;
                    e = e + 1;
                end
            end else begin
                s = mx - my;
                for (int i = 0; i < 11; i++) begin
                    if (s != 12'd0 && !s[10]) begin
                        s = s << 1;
                        e = e - 1;
                    end
                end
            end
            if (s == 12'd0 || e <= 0) r = 16'd0;
            else if (e >= 255)        r = {x[15], 8'hFF, 7'd0};
            else                      r = {x[15], 8'(e), s[9:3]};
        end
        return r;
    endfunction

    function automatic logic [15:0] lane_op(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] ctrl);
        logic [15:0] r;
        case (ctrl)
            4'd0:    r = bf16_addsub(a, b, 1'b0);
            4'd1:    r = bf16_addsub(a, b, 1'b1);
            default: r = a;
        endcase
        return r;
    endfunction

    // Per-lane ALU on the operands latched at DECODE
    always_comb begin
        alu_out = '0;
        for (int unsigned l = 0; l < CORES; l++) begin
            alu_out[l*BITS +: BITS] = lane_op(op_a[l*BITS +: BITS], op_b[l*BITS +: BITS], alu_ctrl);
        end
    end

    // Next-state, datapath updates and register-file write request
    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        loop_nx      = loop_cnt;
        ir_nx        = ir;
        illegal_nx   = illegal;
        cnt_nx       = cnt;
        op_a_nx      = op_a;
        op_b_nx      = op_b;
        mem_we_nx    = mem_we_q;
        mem_addr_nx  = mem_addr_q;
        mem_wdata_nx = mem_wdata_q;
        rf_we        = 1'b0;
        rf_wa        = dst_a;
        rf_wd        = alu_out;

        case (state)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_nx = S_FETCH;
                    pc_nx    = '0;
                    loop_nx  = '0;
                end
            end
            S_FETCH: begin
                if (bus.imem_valid) begin
                    ir_nx    = bus.imem_data;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                op_a_nx      = regs[src1_a];
                op_b_nx      = regs[src2_a];
                mem_wdata_nx = regs[dst_a];
                mem_addr_nx  = imm;
                mem_we_nx    = (op == OP_STORE);
                state_nx     = S_FETCH;
                case (op)
                    OP_ALU: begin
                        cnt_nx   = LAT_W'(ALU_LAT);
                        state_nx = S_EXEC;
                    end
                    OP_STORE, OP_LOAD: state_nx = S_MEM;
                    OP_JUMP:   pc_nx = imm;
                    OP_SETCNT: begin
                        loop_nx = ir[15:0];
                        pc_nx   = pc + PC_W'(1);
                    end
                    OP_LOOP: begin
                        // A zero count falls through so the counter never wraps
                        if (loop_cnt != '0) begin
                            loop_nx = loop_cnt - CNT_W'(1);
                            pc_nx   = imm;
                        end else begin
                            pc_nx = pc + PC_W'(1);
                        end
                    end
                    OP_NOP:  pc_nx = pc + PC_W'(1);
                    OP_HALT: state_nx = S_HALTED;
                    default: begin
                        illegal_nx = 1'b1;
                        pc_nx      = pc + PC_W'(1);
                    end
                endcase
            end
            S_EXEC: begin
                cnt_nx = cnt - LAT_W'(1);
                if (cnt == LAT_W'(1)) begin
                    rf_we    = 1'b1;
                    pc_nx    = pc + PC_W'(1);
                    state_nx = S_FETCH;
                end
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    rf_we    = !mem_we_q;
                    rf_wd    = bus.mem_rdata;
                    pc_nx    = pc + PC_W'(1);
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State and datapath registers; status/request outputs registered from next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= '0;
            loop_cnt    <= '0;
            ir          <= '0;
            illegal     <= 1'b0;
            cnt         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            imem_req_q  <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            loop_cnt    <= loop_nx;
            ir          <= ir_nx;
            illegal     <= illegal_nx;
            cnt         <= cnt_nx;
            op_a        <= op_a_nx;
            op_b        <= op_b_nx;
            mem_we_q    <= mem_we_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_wdata_q <= mem_wdata_nx;
            busy        <= (state_nx != S_IDLE) && (state_nx != S_HALTED);
            halted      <= (state_nx == S_HALTED);
            imem_req_q  <= (state_nx == S_FETCH);
            mem_req_q   <= (state_nx == S_MEM);
        end
    end

    // Register file; a write coinciding with reset is discarded
    always_ff @(posedge clock) begin
        if (rf_we && !reset) begin
            regs[rf_wa] <= rf_wd;
        end
    end
endmodule

// File: tb/tb_simd_processing_unit.sv
// Self-checking bench for simd_processing_unit: table of bf16 lane operations run
// as small programs, plus directed sequences for stalls, loops, pc wrap, illegal
// opcodes and reset in the middle of handshakes.
module tb_simd_processing_unit;
    localparam int unsigned CORES = 32;
    localparam int unsigned BITS  = 16;
    localparam int unsigned PC_W  = 16;
    localparam int unsigned W     = CORES * BITS;

    logic clock, reset, start;
    logic busy, halted, illegal;

    simd_processing_unit_if #(.CORES(CORES), .BITS(BITS), .PC_W(PC_W)) bus ();

    simd_processing_unit #(
        .CORES(CORES), .BITS(BITS), .REG_AW(8), .PC_W(PC_W), .ALU_LAT(1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .halted  (halted),
        .illegal (illegal),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench-side memories and responder knobs
    logic [31:0]     prog [0:65535];
    logic [W-1:0]    dmem [0:255];
    int              imem_delay = 0;
    int              ack_delay  = 0;
    logic            ack_inject = 1'b0;
    logic [PC_W-1:0] watch_addr = '1;
    int              watch_hits = 0;
    int              iwait = 0;
    int              mwait = 0;
    logic            ack_n = 1'b0;
    int              st_cnt = 0;
    logic [PC_W-1:0] st_addr = '0;
    logic [W-1:0]    st_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction-store responder: valid one cycle after a request (plus imem_delay)
    always @(posedge clock) begin
        #1;
        if (reset) begin
            bus.imem_valid = 1'b0;
            iwait = 0;
        end else if (bus.imem_req && !bus.imem_valid) begin
            if (iwait >= imem_delay) begin
                bus.imem_valid = 1'b1;
                bus.imem_data  = prog[bus.imem_addr];
                iwait = 0;
                if (bus.imem_addr == watch_addr) watch_hits++;
            end else begin
                iwait++;
            end
        end else begin
            bus.imem_valid = 1'b0;
            iwait = 0;
        end
    end

    // Main-memory responder: ack after ack_delay extra cycles, log every store
    always @(posedge clock) begin
        #1;
        if (!reset && bus.mem_req && !ack_n) begin
            if (mwait >= ack_delay) begin
                ack_n = 1'b1;
                mwait = 0;
                if (bus.mem_we) begin
                    st_cnt++;
                    st_addr = bus.mem_addr;
                    st_data = bus.mem_wdata;
                end
            end else begin
                mwait++;
            end
        end else begin
            ack_n = 1'b0;
            mwait = 0;
        end
    end

    assign bus.mem_ack   = ack_n | ack_inject;
    assign bus.mem_rdata = dmem[bus.mem_addr[7:0]];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input logic [15:0] v);
        return {CORES{v}};
    endfunction

    function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] ctrl,
                                        input logic [7:0] d, input logic [7:0] s1,
                                        input logic [7:0] s2);
        return {op, ctrl, d, s1, s2};
    endfunction

    function automatic logic [31:0] insi(input logic [3:0] op, input logic [7:0] d,
                                         input logic [15:0] imm);
        return {op, 4'd0, d, imm};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 65536; i++) prog[i] = 32'h6000_0000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        check(name, 512'(halted), 512'(1));
    endtask

    typedef struct {
        string      name;
        logic [3:0] ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        logic            stable;
        logic [PC_W-1:0] addr0, pc0;
        logic [W-1:0]    wd0;
        int              hits0, st0;

        vecs[0] = '{"add_1_2",     4'd0, 16'h3F80, 16'h4000, 16'h4040};
        vecs[1] = '{"sub_2_1",     4'd1, 16'h4000, 16'h3F80, 16'h3F80};
        vecs[2] = '{"sub_neg",     4'd1, 16'h3F80, 16'h4000, 16'hBF80};
        vecs[3] = '{"add_carry",   4'd0, 16'h3FC0, 16'h3FC0, 16'h4040};
        vecs[4] = '{"add_zero",    4'd0, 16'h4120, 16'h0000, 16'h4120};
        vecs[5] = '{"sub_self",    4'd1, 16'h4120, 16'h4120, 16'h0000};
        vecs[6] = '{"move",        4'd2, 16'h1234, 16'h4000, 16'h1234};
        vecs[7] = '{"align_out",   4'd0, 16'h4B80, 16'h3F80, 16'h4B80};
        vecs[8] = '{"overflow",    4'd0, 16'h7F7F, 16'h7F7F, 16'h7F80};
        vecs[9] = '{"add_frac",    4'd0, 16'h3F00, 16'h3E80, 16'h3F40};

        clear_prog();
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check("reset_status", 512'({busy, halted, illegal, bus.imem_req, bus.mem_req}), 512'(0));
        check("reset_addr", 512'({bus.imem_addr, bus.mem_addr, bus.mem_we}), 512'(0));
        check("reset_wdata", 512'(bus.mem_wdata), 512'(0));
        reset = 1'b0;
        tick();

        // Lane arithmetic through LOAD, LOAD, ALU, STORE, HALT
        for (int v = 0; v < 10; v++) begin
            dmem[8'h10] = rep(vecs[v].a);
            dmem[8'h11] = rep(vecs[v].b);
            prog[0] = insi(4'd2, 8'd1, 16'h0010);
            prog[1] = insi(4'd2, 8'd2, 16'h0011);
            prog[2] = ins(4'd0, vecs[v].ctrl, 8'd3, 8'd1, 8'd2);
            prog[3] = insi(4'd1, 8'd3, 16'h0020);
            prog[4] = insi(4'd15, 8'd0, 16'h0000);
            pulse_start();
            run_to_halt({vecs[v].name, "_halt"}, 200);
            check(vecs[v].name, 512'(st_data), 512'(rep(vecs[v].exp)));
            if (v == 0) begin
                check("store_addr", 512'(st_addr), 512'(16'h0020));
                check("halt_pc", 512'(dut.pc), 512'(4));
            end
        end

        // Store held off for 5 cycles: request and payload stay put
        ack_delay = 5;
        clear_prog();
        prog[0] = insi(4'd1, 8'd3, 16'h0022);
        prog[1] = insi(4'd15, 8'd0, 16'h0000);
        st0 = st_cnt;
        pulse_start();
        n = 0;
        while (!bus.mem_req && n < 50) begin
            tick();
            n++;
        end
        check("stall_req_seen", 512'(bus.mem_req), 512'(1));
        addr0 = bus.mem_addr;
        wd0 = bus.mem_wdata;
        pc0 = dut.pc;
        stable = 1'b1;
        n = 0;
        while (bus.mem_req && n < 50) begin
            if (bus.mem_addr !== addr0 || bus.mem_wdata !== wd0 || dut.pc !== pc0 || !bus.mem_we)
                stable = 1'b0;
            tick();
            n++;
        end
        check("stall_req_cycles", 512'(n), 512'(6));
        check("stall_stable", 512'(stable), 512'(1));
        check("stall_addr", 512'(addr0), 512'(16'h0022));
        run_to_halt("stall_halt", 100);
        check("stall_one_store", 512'(st_cnt - st0), 512'(1));
        check("stall_data", 512'(st_data), 512'(rep(16'h3F40)));
        ack_delay = 0;

        // Counted loop: SETCNT 3 runs the body four times
        imem_delay = 2;
        dmem[8'h12] = rep(16'h0000);
        dmem[8'h13] = rep(16'h3F80);
        clear_prog();
        prog[0] = insi(4'd2, 8'd4, 16'h0012);
        prog[1] = insi(4'd2, 8'd5, 16'h0013);
        prog[2] = insi(4'd4, 8'd0, 16'd3);
        prog[3] = ins(4'd0, 4'd0, 8'd4, 8'd4, 8'd5);
        prog[4] = insi(4'd5, 8'd0, 16'd3);
        prog[5] = insi(4'd1, 8'd4, 16'h0024);
        prog[6] = insi(4'd15, 8'd0, 16'h0000);
        watch_addr = 16'd3;
        hits0 = watch_hits;
        pulse_start();
        run_to_halt("loop_halt", 400);
        check("loop_body_runs", 512'(watch_hits - hits0), 512'(4));
        check("loop_cnt_zero", 512'(dut.loop_cnt), 512'(0));
        check("loop_result", 512'(st_data), 512'(rep(16'h4080)));
        check("loop_pc", 512'(dut.pc), 512'(6));
        imem_delay = 0;
        watch_addr = '1;

        // pc wrap after 0xFFFF, then an undefined opcode
        clear_prog();
        prog[0] = insi(4'd3, 8'd0, 16'hFFFF);
        pulse_start();
        n = 0;
        while (!(bus.imem_req && bus.imem_addr == 16'hFFFF) && n < 50) begin
            tick();
            n++;
        end
        check("wrap_fetch_ffff", 512'(bus.imem_addr), 512'(16'hFFFF));
        check("illegal_clear", 512'(illegal), 512'(0));
        prog[0] = 32'h9000_0000;
        prog[1] = insi(4'd15, 8'd0, 16'h0000);
        n = 0;
        while (!(bus.imem_req && bus.imem_addr != 16'hFFFF) && n < 50) begin
            tick();
            n++;
        end
        check("wrap_fetch_zero", 512'({bus.imem_req, bus.imem_addr}), 512'({1'b1, 16'h0000}));
        run_to_halt("illegal_halt", 100);
        check("illegal_set", 512'(illegal), 512'(1));
        check("illegal_pc", 512'(dut.pc), 512'(1));
        prog[0] = insi(4'd15, 8'd0, 16'h0000);
        pulse_start();
        run_to_halt("restart_halt", 100);
        check("illegal_sticky", 512'(illegal), 512'(1));

        // Reset held 3 cycles while running a jump-to-self loop
        prog[0] = insi(4'd3, 8'd0, 16'h0000);
        pulse_start();
        repeat (7) tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("midrun_reset", 512'({busy, halted, illegal, bus.imem_req, bus.mem_req}), 512'(0));
        end
        reset = 1'b0;
        repeat (2) tick();
        check("idle_after_reset", 512'({busy, bus.imem_req}), 512'(0));
        pulse_start();
        check("start_fetch", 512'({bus.imem_req, bus.imem_addr}), 512'({1'b1, 16'h0000}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Reset during a LOAD handshake: ack is dropped and the register keeps its value
        dmem[8'h31] = rep(16'hBEEF);
        dmem[8'h30] = rep(16'h1111);
        clear_prog();
        prog[0] = insi(4'd2, 8'd7, 16'h0031);
        prog[1] = insi(4'd15, 8'd0, 16'h0000);
        pulse_start();
        run_to_halt("preload_halt", 100);
        ack_delay = 1000;
        prog[0] = insi(4'd2, 8'd7, 16'h0030);
        pulse_start();
        n = 0;
        while (!bus.mem_req && n < 50) begin
            tick();
            n++;
        end
        check("rst_mem_req_seen", 512'(bus.mem_req), 512'(1));
        reset = 1'b1;
        ack_inject = 1'b1;
        tick();
        check("rst_mem_dropped", 512'({bus.mem_req, busy}), 512'(0));
        tick();
        reset = 1'b0;
        tick();
        ack_inject = 1'b0;
        ack_delay = 0;
        repeat (2) tick();
        check("rst_mem_idle", 512'({busy, halted, bus.imem_req, bus.mem_req}), 512'(0));
        prog[0] = insi(4'd1, 8'd7, 16'h0040);
        pulse_start();
        run_to_halt("rst_mem_halt", 100);
        check("rst_no_reg_write", 512'(st_data), 512'(rep(16'hBEEF)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
